// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types and constants for the data-cache miss handler.
package dcache_miss_ctrl_pkg;

  localparam int unsigned LineW = 4;
  localparam int unsigned WordW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StWb,
    StFill,
    StInstall
  } miss_state_t;

endpackage

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss handler: bus arbitration, dirty-victim writeback, 4-word line fill
// and install, stalling the pipe until the retried access hits.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int unsigned AddrW = 13,
  parameter int unsigned TagW  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     re,
  input  logic                     we,
  input  logic [AddrW-1:0]         addr,
  input  logic                     hit,
  input  logic                     dirty,
  input  logic [TagW-1:0]          tag_in,
  input  logic [LineW*WordW-1:0]   victim_line,
  output logic                     d_rdy,
  output logic                     wdirty,
  output logic                     fill_we,
  output logic [LineW*WordW-1:0]   fill_line,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [AddrW-1:0]         mem_addr,
  output logic [WordW-1:0]         mem_wdata,
  input  logic [WordW-1:0]         mem_rdata,
  input  logic                     mem_rdy,
  output logic                     read_miss,
  output logic                     write_miss
);

  localparam int unsigned IdxW = AddrW - 2 - TagW;

  miss_state_t                   state_q, state_d;
  logic [1:0]                    cnt_q, cnt_d;
  logic [AddrW-1:0]              addr_q, addr_d;
  logic                          dirty_q, dirty_d;
  logic [TagW-1:0]               tag_q, tag_d;
  logic [LineW-1:0][WordW-1:0]   victim_q, victim_d;
  logic [LineW-1:0][WordW-1:0]   buf_q, buf_d;
  logic                          rd_miss_q, rd_miss_d;
  logic                          wr_miss_q, wr_miss_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      dirty_q   <= 1'b0;
      tag_q     <= '0;
      victim_q  <= '0;
      buf_q     <= '0;
      rd_miss_q <= 1'b0;
      wr_miss_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      dirty_q   <= dirty_d;
      tag_q     <= tag_d;
      victim_q  <= victim_d;
      buf_q     <= buf_d;
      rd_miss_q <= rd_miss_d;
      wr_miss_q <= wr_miss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    dirty_d   = dirty_q;
    tag_d     = tag_q;
    victim_d  = victim_q;
    buf_d     = buf_q;
    rd_miss_d = rd_miss_q;
    wr_miss_d = wr_miss_q;
    d_rdy     = 1'b0;
    wdirty    = 1'b0;
    fill_we   = 1'b0;
    bus_req   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        d_rdy  = ~(re | we) | hit;
        wdirty = we & hit;
        if ((re | we) && !hit) begin
          addr_d    = addr;
          dirty_d   = dirty;
          tag_d     = tag_in;
          victim_d  = victim_line;
          // A simultaneous read and write is serviced as a write.
          rd_miss_d = ~we;
          wr_miss_d = we;
          state_d   = StArb;
        end
      end
      StArb: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          cnt_d   = '0;
          state_d = dirty_q ? StWb : StFill;
        end
      end
      StWb: begin
        bus_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q, addr_q[IdxW+1:2], cnt_q};
        mem_wdata = victim_q[cnt_q];
        if (mem_rdy) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StFill;
        end
      end
      StFill: begin
        bus_req  = 1'b1;
        mem_re   = 1'b1;
        mem_addr = {addr_q[AddrW-1:2], cnt_q};
        if (mem_rdy) begin
          buf_d[cnt_q] = mem_rdata;
          cnt_d        = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Miss flags read as clear while the line installs.
            rd_miss_d = 1'b0;
            wr_miss_d = 1'b0;
            state_d   = StInstall;
          end
        end
      end
      StInstall: begin
        fill_we = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign fill_line  = buf_q;
  assign read_miss  = rd_miss_q;
  assign write_miss = wr_miss_q;

endmodule
